// File: rtl/register_file_wb.sv
// register_file_wb: 32 x N register file with MEM/WB write-back mux; register 0 reads as zero.
// Optional write-through bypass on both read ports when WB_BYPASS_EN is defined.
module register_file_wb #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] ALU_result,
  input  logic [N-1:0] Read_data,
  input  logic [4:0]   WriteRegister,
  input  logic         MemtoReg,
  input  logic         RegWrite,
  input  logic [4:0]   ReadRegister1,
  input  logic [4:0]   ReadRegister2,
  output logic [N-1:0] ReadData1,
  output logic [N-1:0] ReadData2,
  output logic [N-1:0] WriteData
);

  logic [N-1:0] regs [32];
  logic         write_en;

  assign WriteData = MemtoReg ? Read_data : ALU_result;
  assign write_en  = RegWrite && (WriteRegister != 5'd0);

  // Entry 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  always_comb begin
    ReadData1 = regs[ReadRegister1];
    ReadData2 = regs[ReadRegister2];
`ifdef WB_BYPASS_EN
    if (write_en && (ReadRegister1 == WriteRegister)) ReadData1 = WriteData;
    if (write_en && (ReadRegister2 == WriteRegister)) ReadData2 = WriteData;
`endif
    // Reset and index 0 override everything, including the bypass path.
    if (!reset || (ReadRegister1 == 5'd0)) ReadData1 = '0;
    if (!reset || (ReadRegister2 == 5'd0)) ReadData2 = '0;
  end

endmodule
